fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one fifo instance among NUM_REQ producers. It issues at most one write per cycle into the FIFO and never asserts a write while the FIFO reports full. Ownership is held for multi-beat packets until the owner's last beat is transferred. It sits directly in front of the fifo write port (wr_en, data_in, full).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, data beat width; must match the downstream fifo
MAX_PKT, 16, maximum beats per packet before forced release (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks the final beat of a packet
req_ready  output  NUM_REQ  one-hot grant; a beat transfers when req_valid[i] && req_ready[i]
fifo_full  input  1  full flag from the fifo
fifo_wr_en  output  1  write strobe to the fifo
fifo_data  output  DATA_WIDTH  write data to the fifo
owner  output  clog2(NUM_REQ)  index of the current or last owner (registered)
locked  output  1  high while a packet is in progress (registered)
pkt_err  output  1  one-cycle pulse when MAX_PKT forces release

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, owner=0, locked=0, beat_cnt=0, pkt_err=0. req_ready=0 and fifo_wr_en=0 while reset is high.
- Combinational paths: req_ready, fifo_wr_en and fifo_data are combinational from inputs and state, giving zero-latency transfer.
- Invariants:
  - fifo_wr_en = |(req_valid & req_ready).
  - fifo_wr_en is never high while fifo_full=1.
  - req_ready is all-zero whenever fifo_full=1.
  - fifo_data = beat of the granted requester, or 0 when there is no grant.
- State IDLE:
  - Candidate = first i with req_valid[i] set, searching (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - If a candidate exists and !fifo_full: req_ready[cand]=1 and the beat transfers.
  - Next state, when req_last[cand]=1 (or MAX_PKT=1): rr_ptr <= cand+1 mod NUM_REQ and stay in IDLE (single-beat packet).
  - Next state, otherwise: owner <= cand, locked <= 1, beat_cnt <= 1, go to LOCKED.
- State LOCKED:
  - Only the owner may be granted: req_ready[owner] = !fifo_full.
  - Other requesters are ignored regardless of their valid.
  - An owner valid gap does not release the lock.
  - On each transfer, beat_cnt increments.
  - Release to IDLE on a transfer with req_last=1. Also release when that transfer makes beat_cnt == MAX_PKT; in that case pulse pkt_err for one cycle.
  - On release: rr_ptr <= owner+1 mod NUM_REQ, locked <= 0, beat_cnt <= 0. The owner output holds its last value.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. owner and rr_ptr are at most clog2(NUM_REQ) bits, minimum width 1.
- fifo_full rises mid-packet: the lock is held and the transfer stalls; nothing is dropped or reordered.
- Reset mid-packet: the lock is abandoned and state returns to the reset values on the next edge. The partial packet already written stays in the fifo; the fifo's own reset clears it.
- Requester rules: a requester must hold its data and last stable while valid && !ready. Deasserting valid without a transfer is legal and is not an error.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function
  - state encoding localparams ST_IDLE=1'b0, ST_LOCKED=1'b1
  - DATA_WIDTH default constant shared with fifo
- Sub-module rr_pick:
  - Purely combinational rotate-priority search.
  - Inputs: NUM_REQ-bit request, start index.
  - Outputs: found flag, index.
  - Keeps the arbiter FSM readable and unit-testable.
- fifo_wr_arbiter contains the FSM, counters and the data mux.
- A top-level wrapper wires fifo_wr_arbiter to fifo (fifo_wr_en->wr_en, fifo_data->data_in, full->fifo_full).

Test Plan:
- Reset, then req_valid=4'b1111, all req_last=1, fifo never full -> grants in order 0,1,2,3,0; one write per cycle; data order matches.
- Requester 2 sends 3-beat packet A0,A1,A2 while req 0 and 1 are valid -> ready stays one-hot on 2 for 3 transfers; then rr_ptr=3 and next grant goes to 0 (req 3 idle).
- fifo_full=1 for 4 cycles in the middle of req 1's packet -> req_ready=0 and fifo_wr_en=0 throughout; packet resumes in the same owner; locked=1 throughout.
- MAX_PKT=4, requester 0 sends 6 beats with no last -> release after 4th beat; pkt_err pulses one cycle; the next grant is round-robin from 1.
- reset asserted while locked with beat_cnt=2 -> next cycle: locked=0, owner=0, rr_ptr=0, req_ready=0, fifo_wr_en=0.
- Drive fifo_full=1 with random valids for 1000 cycles, then random full -> a checker asserts fifo_wr_en & fifo_full is never 1 and req_ready is always one-hot or zero.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo write-side arbiter and the fifo it feeds.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Index width for n items; never narrower than one bit so n=1/2 still yields a usable port.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at or after start, wrapping modulo N.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Walk from the farthest slot back so the nearest hit is written last.
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = (int'(start) + k) % N;
         if (req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers with packet locking.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no packet open; rotate-priority pick starting at rr_ptr
// ST_LOCKED | multi-beat packet open; only owner may write until release
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int MAX_PKT    = 16,
   localparam int IW        = clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [IW-1:0]                 owner,
   output logic                          locked,
   output logic                          pkt_err
);

   arb_state_e    state;
   logic [IW-1:0] rr_ptr;
   logic [7:0]    beat_cnt;
   logic [7:0]    cnt_next;

   logic          cand_found;
   logic [IW-1:0] cand;
   logic [IW-1:0] gidx;
   logic          xfer;
   logic          last_beat;

   function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
      return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req   (req_valid),
      .start (rr_ptr),
      .found (cand_found),
      .idx   (cand)
   );

   assign gidx = (state == ST_IDLE) ? cand : owner;

   always_comb begin
      req_ready = '0;
      if (!reset && !fifo_full) begin
         if (state == ST_IDLE) begin
            if (cand_found) req_ready[cand] = 1'b1;
         end else begin
            req_ready[owner] = 1'b1;
         end
      end
   end

   assign xfer       = |(req_valid & req_ready);
   assign fifo_wr_en = xfer;
   assign fifo_data  = xfer ? req_data[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign last_beat  = req_last[gidx];
   assign cnt_next   = beat_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         locked   <= 1'b0;
         beat_cnt <= '0;
         pkt_err  <= 1'b0;
      end else begin
         pkt_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (last_beat || MAX_PKT == 1) begin
                     rr_ptr <= inc_ptr(cand);
                  end else begin
                     owner    <= cand;
                     locked   <= 1'b1;
                     beat_cnt <= 8'd1;
                     state    <= ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               if (xfer) begin
                  if (last_beat || cnt_next == 8'(MAX_PKT)) begin
                     // A genuine last beat landing exactly on the limit is a clean packet.
                     pkt_err  <= !last_beat;
                     rr_ptr   <= inc_ptr(owner);
                     locked   <= 1'b0;
                     beat_cnt <= '0;
                     state    <= ST_IDLE;
                  end else begin
                     beat_cnt <= cnt_next;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed grants, plus full/one-hot invariant sweeps.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_data;
   logic [1:0]    owner;
   logic          locked;
   logic          pkt_err;

   int vectors = 0;
   int miscompares = 0;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_data  (fifo_data),
      .owner      (owner),
      .locked     (locked),
      .pkt_err    (pkt_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int i, input logic [7:0] d, input logic l);
      req_data[i*DW +: DW] = d;
      req_last[i] = l;
   endtask

   initial begin
      reset     = 1'b1;
      fifo_full = 1'b0;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);

      // reset holds grants off even with every requester valid
      tick();
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      tick();
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_pkt_err", 32'(pkt_err), 32'h0);
      reset = 1'b0;

      // all valid, single-beat packets: 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
         chk("rr_wr_en", 32'(fifo_wr_en), 32'h1);
         chk("rr_data", 32'(fifo_data), 32'hA0 + 32'(k % 4));
         tick();
      end
      chk("rr_locked", 32'(locked), 32'h0);

      // rr_ptr=1: one beat from req 1 moves pointer to 2
      req_valid = 4'b0010;
      #1;
      chk("p1_ready", 32'(req_ready), 32'h2);
      tick();

      // req 2 three-beat packet while 0 and 1 also valid
      req_valid = 4'b0111;
      set_beat(2, 8'hC0, 1'b0);
      for (int b = 0; b < 3; b++) begin
         set_beat(2, 8'hC0 + 8'(b), (b == 2));
         #1;
         chk("pk_ready", 32'(req_ready), 32'h4);
         chk("pk_data", 32'(fifo_data), 32'hC0 + 32'(b));
         tick();
         chk("pk_locked", 32'(locked), (b == 2) ? 32'h0 : 32'h1);
         chk("pk_owner", 32'(owner), 32'h2);
      end
      req_valid = 4'b0011;
      #1;
      chk("after_pk_ready", 32'(req_ready), 32'h1);
      tick();

      // req 1 packet with a 4-cycle full stall in the middle; rr_ptr=1 now
      req_valid = 4'b0010;
      set_beat(1, 8'hB0, 1'b0);
      #1;
      chk("st_b0_ready", 32'(req_ready), 32'h2);
      chk("st_b0_data", 32'(fifo_data), 32'hB0);
      tick();
      chk("st_locked0", 32'(locked), 32'h1);
      chk("st_owner", 32'(owner), 32'h1);
      set_beat(1, 8'hB1, 1'b0);
      #1;
      chk("st_b1_data", 32'(fifo_data), 32'hB1);
      tick();
      req_valid = 4'b0011;
      set_beat(1, 8'hB2, 1'b1);
      fifo_full = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("st_full_ready", 32'(req_ready), 32'h0);
         chk("st_full_wr_en", 32'(fifo_wr_en), 32'h0);
         tick();
         chk("st_full_locked", 32'(locked), 32'h1);
      end
      fifo_full = 1'b0;
      #1;
      chk("st_resume_ready", 32'(req_ready), 32'h2);
      chk("st_resume_data", 32'(fifo_data), 32'hB2);
      tick();
      chk("st_released", 32'(locked), 32'h0);
      chk("st_no_err", 32'(pkt_err), 32'h0);

      // MAX_PKT=4 forced release; rr_ptr=2, only req 0 valid
      req_valid = 4'b0001;
      for (int b = 0; b < 4; b++) begin
         set_beat(0, 8'h50 + 8'(b), 1'b0);
         #1;
         chk("mx_ready", 32'(req_ready), 32'h1);
         chk("mx_data", 32'(fifo_data), 32'h50 + 32'(b));
         tick();
         chk("mx_locked", 32'(locked), (b == 3) ? 32'h0 : 32'h1);
         chk("mx_pkt_err", 32'(pkt_err), (b == 3) ? 32'h1 : 32'h0);
      end
      req_valid = 4'b0011;
      set_beat(0, 8'h54, 1'b0);
      set_beat(1, 8'h61, 1'b1);
      #1;
      chk("mx_next_ready", 32'(req_ready), 32'h2);
      chk("mx_next_data", 32'(fifo_data), 32'h61);
      tick();
      chk("mx_err_pulse_end", 32'(pkt_err), 32'h0);

      // reset mid-packet: req 3 locked with two beats written (rr_ptr=2)
      req_valid = 4'b1000;
      set_beat(3, 8'h70, 1'b0);
      tick();
      tick();
      chk("mr_locked", 32'(locked), 32'h1);
      chk("mr_owner", 32'(owner), 32'h3);
      reset = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("mr_rst_ready", 32'(req_ready), 32'h0);
      chk("mr_rst_wr_en", 32'(fifo_wr_en), 32'h0);
      tick();
      chk("mr_locked_clr", 32'(locked), 32'h0);
      chk("mr_owner_clr", 32'(owner), 32'h0);
      reset = 1'b0;
      req_last = 4'b1111;
      #1;
      chk("mr_rrptr_zero", 32'(req_ready), 32'h1);
      tick();

      // full held with random requests: nothing may be granted
      fifo_full = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         req_valid = 4'($urandom);
         req_last  = 4'($urandom);
         req_data  = 32'($urandom);
         #1;
         chk("rf_ready", 32'(req_ready), 32'h0);
         chk("rf_wr_en", 32'(fifo_wr_en), 32'h0);
         tick();
      end

      // random full: invariants only
      for (int c = 0; c < 500; c++) begin
         fifo_full = 1'($urandom);
         req_valid = 4'($urandom);
         req_last  = 4'($urandom);
         req_data  = 32'($urandom);
         #1;
         chk("rx_full_wr", 32'(fifo_wr_en & fifo_full), 32'h0);
         chk("rx_onehot0", 32'($onehot0(req_ready)), 32'h1);
         chk("rx_wr_en", 32'(fifo_wr_en), 32'(|(req_valid & req_ready)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
